// File: rtl/imem_loadable.sv
// Loadable instruction memory: synchronous 1-cycle fetch with stall/error handling,
// plus a streaming loader FSM that writes program words at run time.
module imem_loadable #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req_i,
    input  logic [ADDR_W-1:0]   fetch_addr_i,
    input  logic                stall_i,
    output logic                fetch_ready_o,
    output logic                inst_valid_o,
    output logic [DATA_W-1:0]   inst_o,
    output logic                inst_err_o,
    input  logic                ld_start_i,
    input  logic [ADDR_W-3:0]   ld_base_i,
    input  logic [LEN_W-1:0]    ld_len_i,
    input  logic                ld_valid_i,
    input  logic [DATA_W-1:0]   ld_data_i,
    output logic                ld_ready_o,
    output logic                ld_busy_o,
    output logic                ld_done_o,
    output logic                ld_err_o,
    output logic [LEN_W-1:0]    ld_count_o
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                mem_we;

    logic [DATA_W-1:0]   inst_q;
    logic                inst_valid_q;
    logic                inst_err_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    fetch_idx;
    logic                fetch_bad;
    logic                fetch_acc;
    logic                ptr_in_range;

    assign fetch_idx    = fetch_addr_i[ADDR_W-1:2];
    assign fetch_bad    = (fetch_addr_i[1:0] != 2'b00) || (32'(fetch_idx) >= DEPTH);
    assign ptr_in_range = 32'(ptr_q) < DEPTH;

    // ld_start wins over a same-cycle fetch so the load session starts cleanly
    assign fetch_ready_o = (state_q == ST_RUN) && !stall_i && !ld_start_i;
    assign fetch_acc     = fetch_req_i && fetch_ready_o;
    assign ld_ready_o    = (state_q == ST_LOAD);
    assign ld_busy_o     = (state_q == ST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (ld_start_i) begin
                    state_d = ST_LOAD;
                    ptr_d   = ld_base_i;
                    rem_d   = ld_len_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                // zero-length session exits immediately without writing
                if (rem_q == '0) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else if (ld_valid_i) begin
                    if (ptr_in_range) begin
                        mem_we = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    ptr_d = ptr_q + IDX_W'(1);
                    cnt_d = cnt_q + LEN_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Array deliberately unreset so loaded programs survive rst_n
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[MEM_AW-1:0]] <= ld_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_err_q   <= 1'b0;
        end else if (fetch_acc) begin
            inst_valid_q <= 1'b1;
            inst_err_q   <= fetch_bad;
            inst_q       <= fetch_bad ? '0 : mem[fetch_idx[MEM_AW-1:0]];
        end else if (!(stall_i && state_q == ST_RUN)) begin
            inst_valid_q <= 1'b0;
        end
    end

    assign inst_o       = inst_q;
    assign inst_valid_o = inst_valid_q;
    assign inst_err_o   = inst_err_q;
    assign ld_done_o    = done_q;
    assign ld_err_o     = err_q;
    assign ld_count_o   = cnt_q;

endmodule
